branch_predict_resolver: RTL

ID-stage branch unit that evaluates the branch condition and owns a direct-mapped branch history table (BHT) of saturating counters.
- IF side: the BHT supplies a taken/not-taken prediction for the fetch PC.
- ID side: the block resolves the actual outcome, flags mispredictions for the flush/redirect logic, and trains the BHT.
- Replaces the purely combinational taken check; jump-target generation stays in jump_ctrl.

---
 rtl/branch_predict_resolver_pkg.sv | 20 ++
 rtl/branch_predict_resolver_cond_eval.sv | 66 ++++++
 rtl/branch_predict_resolver.sv | 138 +++++++++++++
 3 files changed

// File: rtl/branch_predict_resolver_pkg.sv
// branch_predict_resolver_pkg
//   Shared constants for the ID-stage branch unit: opcode and REGIMM rt codes
//   for the conditional branches, and the BHT counter reset value.
package branch_predict_resolver_pkg;

  // Primary opcodes of the conditional branches
  localparam logic [5:0] OP_BLTZ_BGEZ = 6'h01;  // REGIMM, sub-op in rt
  localparam logic [5:0] OP_BEQ       = 6'h04;
  localparam logic [5:0] OP_BNE       = 6'h05;
  localparam logic [5:0] OP_BLEZ      = 6'h06;
  localparam logic [5:0] OP_BGTZ      = 6'h07;

  // REGIMM rt sub-op codes
  localparam logic [4:0] RT_BLTZ = 5'h00;
  localparam logic [4:0] RT_BGEZ = 5'h01;

  // Every BHT counter starts weakly not-taken
  localparam logic [1:0] BHT_INIT = 2'b01;

endpackage

// File: rtl/branch_predict_resolver_cond_eval.sv
// branch_cond_eval
//   Purely combinational branch condition evaluation. Operands are compared
//   as signed values. Not qualified by instruction validity; the caller does
//   that.
//   Ports:
//     op, rt        : opcode and rt field of the instruction
//     rsv, rtv      : forwarded rs / rt operand values (signed)
//     is_branch     : instruction is a recognised conditional branch
//     branch_taken  : condition holds (0 for non-branches)
module branch_cond_eval
  import branch_predict_resolver_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        op,
  input  logic [4:0]        rt,
  input  logic [DATA_W-1:0] rsv,
  input  logic [DATA_W-1:0] rtv,
  output logic              is_branch,
  output logic              branch_taken
);

  logic signed [DATA_W-1:0] rs_s;
  logic signed [DATA_W-1:0] rt_s;

  assign rs_s = $signed(rsv);
  assign rt_s = $signed(rtv);

  always_comb begin
    is_branch    = 1'b0;
    branch_taken = 1'b0;
    unique case (op)
      OP_BEQ: begin
        is_branch    = 1'b1;
        branch_taken = (rs_s == rt_s);
      end
      OP_BNE: begin
        is_branch    = 1'b1;
        branch_taken = (rs_s != rt_s);
      end
      OP_BLEZ: begin
        is_branch    = 1'b1;
        branch_taken = (rs_s <= 0);
      end
      OP_BGTZ: begin
        is_branch    = 1'b1;
        branch_taken = (rs_s > 0);
      end
      OP_BLTZ_BGEZ: begin
        // Only BLTZ/BGEZ are handled; other REGIMM sub-ops are not branches here
        if (rt == RT_BGEZ) begin
          is_branch    = 1'b1;
          branch_taken = (rs_s >= 0);
        end else if (rt == RT_BLTZ) begin
          is_branch    = 1'b1;
          branch_taken = (rs_s < 0);
        end
      end
      default: begin
        is_branch    = 1'b0;
        branch_taken = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/branch_predict_resolver.sv
// branch_predict_resolver
//   ID-stage branch unit. Resolves conditional branches, flags mispredictions
//   and trains a direct-mapped table of saturating counters that also supplies
//   the IF-stage prediction.
//   Optional macro: BP_STATS_EN adds branch / mispredict statistic counters.
//   Ports:
//     clk, rst_n         : clock, asynchronous active-low reset
//     if_pc / pred_taken : fetch PC lookup, combinational prediction (counter MSB)
//     id_valid, id_stall : ID holds a real instruction / ID frozen (no training)
//     id_pc, id_op, id_rt, id_rsv, id_rtv, id_pred_taken : ID instruction info
//     is_branch, branch_taken, mispredict : combinational resolution results
//     stat_branches, stat_mispredicts     : (BP_STATS_EN only) trained counts
module branch_predict_resolver
  import branch_predict_resolver_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   if_pc,
  output logic              pred_taken,
  input  logic              id_valid,
  input  logic              id_stall,
  input  logic [PC_W-1:0]   id_pc,
  input  logic [5:0]        id_op,
  input  logic [4:0]        id_rt,
  input  logic [DATA_W-1:0] id_rsv,
  input  logic [DATA_W-1:0] id_rtv,
  input  logic              id_pred_taken,
  output logic              is_branch,
  output logic              branch_taken,
  output logic              mispredict
`ifdef BP_STATS_EN
  ,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BHT_INIT);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Counter table held in flops so the whole table clears on async reset
  logic [CNT_W-1:0] bht_q [BHT_DEPTH];
  logic [CNT_W-1:0] bht_d [BHT_DEPTH];

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] id_idx;
  logic [CNT_W-1:0] id_cnt;
  logic             cond_is_branch;
  logic             cond_taken;
  logic             train_en;

  // Word-aligned PCs: drop the two byte-offset bits
  assign if_idx = if_pc[IDX_W+1:2];
  assign id_idx = id_pc[IDX_W+1:2];
  assign id_cnt = bht_q[id_idx];

  // High and byte-offset PC bits are deliberately ignored by the index
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                            id_pc[PC_W-1:IDX_W+2], id_pc[1:0]};

  // Prediction reads the registered table: same-cycle training is not bypassed
  assign pred_taken = bht_q[if_idx][CNT_W-1];

  branch_cond_eval #(.DATA_W(DATA_W)) u_cond_eval (
    .op           (id_op),
    .rt           (id_rt),
    .rsv          (id_rsv),
    .rtv          (id_rtv),
    .is_branch    (cond_is_branch),
    .branch_taken (cond_taken)
  );

  assign is_branch    = id_valid & cond_is_branch;
  assign branch_taken = is_branch & cond_taken;
  // A non-branch predicted taken also redirects: fetch went down a bogus path
  assign mispredict   = id_valid & ((is_branch & (branch_taken != id_pred_taken)) |
                                    (~is_branch & id_pred_taken));
  assign train_en     = id_valid & ~id_stall;

  always_comb begin
    bht_d = bht_q;
    if (train_en) begin
      if (is_branch) begin
        if (branch_taken) begin
          if (id_cnt != CNT_MAX) bht_d[id_idx] = id_cnt + 1'b1;
        end else begin
          if (id_cnt != '0) bht_d[id_idx] = id_cnt - 1'b1;
        end
      end else if (id_pred_taken) begin
        // Scrub an aliased entry that made a non-branch look taken
        bht_d[id_idx] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CNT_INIT;
    end else begin
      bht_q <= bht_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (train_en) begin
      stat_branches_d    = stat_branches_q + 32'(is_branch);
      stat_mispredicts_d = stat_mispredicts_q + 32'(mispredict);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule
